serial_parity_rx: RTL

- Receiver end of the team's serial parity link.
- Deserialises frames laid out as: start bit, DATA_W data bits (LSB first), one parity bit.
- Keeps a running XOR of the data bits and compares it with the received parity bit.
- Presents the parallel word with a one-cycle valid pulse and a parity-error flag to downstream datapath logic.

---
 rtl/serial_parity_pkg.sv | 15 +
 rtl/par_shift_acc.sv | 28 ++
 rtl/serial_parity_rx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_parity_pkg.sv
// Shared types and line levels for the serial parity link receiver.
package serial_parity_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      DONE
   } state_t;

   localparam logic START_LVL = 1'b0;
   localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/par_shift_acc.sv
// LSB-first deserialising shift register with a running XOR of every bit shifted in.
module par_shift_acc #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              shiftEn,
   input  logic              bitIn,
   output logic [DATA_W-1:0] word,
   output logic              acc
);

   // New bits enter at the top so the first bit received ends up in bit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word <= '0;
         acc  <= 1'b0;
      end else if (clear) begin
         word <= '0;
         acc  <= 1'b0;
      end else if (shiftEn) begin
         word <= {bitIn, word[DATA_W-1:1]};
         acc  <= acc ^ bitIn;
      end
   end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial parity link receiver: start bit, DATA_W data bits LSB first, parity bit.
// Define SERIAL_STOP_BIT_EN to require a trailing stop bit and add the frameErr output.
module serial_parity_rx
   import serial_parity_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter bit ODD_PAR = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              serIn,
   input  logic              serValid,
   output logic [DATA_W-1:0] dataOut,
   output logic              dataValid,
   output logic              parityErr,
   output logic              busy
`ifdef SERIAL_STOP_BIT_EN
   ,
   output logic              frameErr
`endif
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   state_t             state;
   state_t             stateNext;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cntNext;
   logic               clear;
   logic               shiftEn;
   logic               load;
   logic               errNext;
   logic [DATA_W-1:0]  word;
   logic               acc;
`ifdef SERIAL_STOP_BIT_EN
   logic               pendErr;
   logic               pendErrNext;
   logic               frameErrNext;
`endif

   par_shift_acc #(
      .DATA_W (DATA_W)
   ) shifter (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .shiftEn (shiftEn),
      .bitIn   (serIn),
      .word    (word),
      .acc     (acc)
   );

   // Every transition is gated by serValid except DONE, which always leaves after one cycle.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      clear     = 1'b0;
      shiftEn   = 1'b0;
      load      = 1'b0;
      errNext   = parityErr;
`ifdef SERIAL_STOP_BIT_EN
      pendErrNext  = pendErr;
      frameErrNext = frameErr;
`endif
      case (state)
         IDLE: begin
            if (serValid && (serIn != IDLE_LVL)) begin
               stateNext = DATA;
               cntNext   = '0;
               clear     = 1'b1;
            end
         end
         DATA: begin
            if (serValid) begin
               shiftEn = 1'b1;
               cntNext = cnt + 1'b1;
               if (cnt == CNT_W'(DATA_W - 1)) begin
                  stateNext = PARITY;
               end
            end
         end
         PARITY: begin
            if (serValid) begin
`ifdef SERIAL_STOP_BIT_EN
               pendErrNext = serIn ^ acc ^ ODD_PAR;
               stateNext   = STOP;
`else
               errNext   = serIn ^ acc ^ ODD_PAR;
               load      = 1'b1;
               stateNext = DONE;
`endif
            end
         end
`ifdef SERIAL_STOP_BIT_EN
         STOP: begin
            if (serValid) begin
               errNext      = pendErr;
               frameErrNext = (serIn != IDLE_LVL);
               load         = 1'b1;
               stateNext    = DONE;
            end
         end
`endif
         DONE: begin
            // A start bit here chains straight into the next frame with no gap cycle.
            if (serValid && (serIn == START_LVL)) begin
               stateNext = DATA;
               cntNext   = '0;
               clear     = 1'b1;
            end else begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         dataOut   <= '0;
         dataValid <= 1'b0;
         parityErr <= 1'b0;
`ifdef SERIAL_STOP_BIT_EN
         pendErr   <= 1'b0;
         frameErr  <= 1'b0;
`endif
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         dataValid <= load;
         parityErr <= errNext;
         if (load) begin
            dataOut <= word;
         end
`ifdef SERIAL_STOP_BIT_EN
         pendErr   <= pendErrNext;
         frameErr  <= frameErrNext;
`endif
      end
   end

   assign busy = (state != IDLE);

endmodule
